// File: rtl/wb_stage_if.sv
// M->W pipeline interface: the M-stage values entering writeback and the
// GRF write port plus W-stage state that decode reads back.
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      IR_M;
    logic [31:0]      pc_M;
    logic [31:0]      ALUout_M;
    logic [31:0]      dm_rdata_M;
    logic [31:0]      IR_W;
    logic [31:0]      pc_W;
    logic             regWrite_W;
    logic [4:0]       mul_A3;
    logic [31:0]      mul_WD;
    logic [CNT_W-1:0] retire_cnt;

    // Upstream side: supplies the M-stage instruction, observes the write port.
    modport master (
        output IR_M, pc_M, ALUout_M, dm_rdata_M,
        input  IR_W, pc_W, regWrite_W, mul_A3, mul_WD, retire_cnt
    );

    // Writeback stage itself.
    modport slave (
        input  IR_M, pc_M, ALUout_M, dm_rdata_M,
        output IR_W, pc_W, regWrite_W, mul_A3, mul_WD, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// W-stage writeback: registers M/W state, decodes the destination register,
// aligns/extends load data and drives the GRF write port. Also counts
// non-bubble instructions entering W.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      ir_q;
    logic [31:0]      pc_q;
    logic [31:0]      alu_q;
    logic [31:0]      dm_q;
    logic [CNT_W-1:0] cnt_q;

    // M/W pipeline register and retired-instruction counter; W never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            pc_q  <= '0;
            alu_q <= '0;
            dm_q  <= '0;
            cnt_q <= '0;
        end else begin
            ir_q  <= bus.IR_M;
            pc_q  <= bus.pc_M;
            alu_q <= bus.ALUout_M;
            dm_q  <= bus.dm_rdata_M;
            if (bus.IR_M != 32'd0) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];

    // Pick the addressed byte/halfword out of the loaded word; alu_q[0] is
    // deliberately ignored for halfword loads.
    always_comb begin
        ld_byte = dm_q[7:0];
        case (alu_q[1:0])
            2'd0:    ld_byte = dm_q[7:0];
            2'd1:    ld_byte = dm_q[15:8];
            2'd2:    ld_byte = dm_q[23:16];
            default: ld_byte = dm_q[31:24];
        endcase
        ld_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
    end

    logic        wr_en;
    logic [4:0]  wr_dst;
    logic [31:0] wr_data;

    // Destination and write-back value per instruction class.
    always_comb begin
        wr_en   = 1'b0;
        wr_dst  = 5'd0;
        wr_data = 32'd0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    wr_en   = 1'b1;
                    wr_dst  = rd;
                    wr_data = alu_q;
                end
            end
            OP_ORI, OP_LUI: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = alu_q;
            end
            OP_LW: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = dm_q;
            end
            OP_LB: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = {{24{ld_byte[7]}}, ld_byte};
            end
            OP_LBU: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = {24'd0, ld_byte};
            end
            OP_LH: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = {{16{ld_half[15]}}, ld_half};
            end
            OP_LHU: begin
                wr_en   = 1'b1;
                wr_dst  = rt;
                wr_data = {16'd0, ld_half};
            end
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_dst  = 5'd31;
                wr_data = pc_q + 32'd8;
            end
            default: begin
                wr_en   = 1'b0;
            end
        endcase
    end

    logic write_ok;

    // $0 is never presented as a write target; a suppressed write drives all zeros.
    assign write_ok = wr_en && (wr_dst != 5'd0);

    assign bus.IR_W       = ir_q;
    assign bus.pc_W       = pc_q;
    assign bus.regWrite_W = write_ok;
    assign bus.mul_A3     = write_ok ? wr_dst  : 5'd0;
    assign bus.mul_WD     = write_ok ? wr_data : 32'd0;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expected write-port values.
module tb_wb_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] exp_cnt;

    wb_stage_if #(.CNT_W(32)) bus ();

    wb_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm);
        bus.IR_M       = ir;
        bus.pc_M       = pc;
        bus.ALUout_M   = alu;
        bus.dm_rdata_M = dm;
    endtask

    // Present one instruction, clock it into W, then check the write port.
    task automatic step(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic exp_we, input logic [4:0] exp_a3,
                        input logic [31:0] exp_wd);
        drive(ir, pc, alu, dm);
        @(posedge clk);
        #1;
        if (ir != 32'd0) exp_cnt = exp_cnt + 32'd1;
        check({tag, ".IR_W"}, bus.IR_W, ir);
        check({tag, ".pc_W"}, bus.pc_W, pc);
        check({tag, ".we"},   {31'd0, bus.regWrite_W}, {31'd0, exp_we});
        check({tag, ".A3"},   {27'd0, bus.mul_A3}, {27'd0, exp_a3});
        check({tag, ".WD"},   bus.mul_WD, exp_wd);
        check({tag, ".cnt"},  bus.retire_cnt, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = 32'd0;

        // Reset held two edges with a live lui on the M inputs.
        reset = 1'b1;
        drive(32'h3c01ffff, 32'h0000_2ffc, 32'hffff_0000, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.IR_W", bus.IR_W, 32'h0);
        check("rst.pc_W", bus.pc_W, 32'h0);
        check("rst.we",   {31'd0, bus.regWrite_W}, 32'h0);
        check("rst.A3",   {27'd0, bus.mul_A3}, 32'h0);
        check("rst.WD",   bus.mul_WD, 32'h0);
        check("rst.cnt",  bus.retire_cnt, 32'h0);

        step("lui1",   32'h3c01ffff, 32'h0000_2ffc, 32'hffff_0000, 32'h0,         1'b1, 5'd1,  32'hffff_0000);
        step("ori2",   32'h34021234, 32'h0000_3000, 32'h0000_1234, 32'h0,         1'b1, 5'd2,  32'h0000_1234);
        step("ori2b",  32'h34025678, 32'h0000_3004, 32'h0000_5678, 32'h0,         1'b1, 5'd2,  32'h0000_5678);
        step("lb_p",   32'h80030000, 32'h0000_3008, 32'h0000_0005, 32'h12A4_5678, 1'b1, 5'd3,  32'h0000_0056);
        step("lb_n",   32'h80030000, 32'h0000_300c, 32'h0000_0005, 32'h12A4_8078, 1'b1, 5'd3,  32'hFFFF_FF80);
        step("lbu",    32'h90030000, 32'h0000_3010, 32'h0000_0005, 32'h12A4_8078, 1'b1, 5'd3,  32'h0000_0080);
        step("lb_o3",  32'h80030000, 32'h0000_3014, 32'h0000_0007, 32'h92A4_5678, 1'b1, 5'd3,  32'hFFFF_FF92);
        step("lbu_o0", 32'h90030000, 32'h0000_3018, 32'h0000_0004, 32'h12A4_56F8, 1'b1, 5'd3,  32'h0000_00F8);
        step("lh_h1",  32'h84040000, 32'h0000_301c, 32'h0000_0002, 32'h8001_7FFF, 1'b1, 5'd4,  32'hFFFF_8001);
        step("lhu_h1", 32'h94040000, 32'h0000_3020, 32'h0000_0002, 32'h8001_7FFF, 1'b1, 5'd4,  32'h0000_8001);
        step("lh_b0",  32'h84040000, 32'h0000_3024, 32'h0000_0003, 32'h8001_7FFF, 1'b1, 5'd4,  32'hFFFF_8001);
        step("lh_h0",  32'h84040000, 32'h0000_3028, 32'h0000_0000, 32'h8001_7FFF, 1'b1, 5'd4,  32'h0000_7FFF);
        step("lw",     32'h8C050000, 32'h0000_302c, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF);
        step("subu",   32'h00223023, 32'h0000_3030, 32'h0000_00AA, 32'h0,         1'b1, 5'd6,  32'h0000_00AA);
        step("addu7",  32'h00223821, 32'h0000_3034, 32'h1234_5678, 32'h0,         1'b1, 5'd7,  32'h1234_5678);
        step("jal",    32'h0C000C04, 32'h0000_3010, 32'h0,         32'h0,         1'b1, 5'd31, 32'h0000_3018);
        step("jalwrap",32'h0C000C04, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 5'd31, 32'h0000_0004);
        step("addu0",  32'h00220021, 32'h0000_3040, 32'h0000_0003, 32'h0,         1'b0, 5'd0,  32'h0);
        step("sw",     32'hAC010000, 32'h0000_3044, 32'h0000_0020, 32'h5555_5555, 1'b0, 5'd0,  32'h0);
        step("bubble", 32'h00000000, 32'h0000_3048, 32'h0000_0040, 32'h6666_6666, 1'b0, 5'd0,  32'h0);
        step("and",    32'h00223024, 32'h0000_304c, 32'h0000_0001, 32'h0,         1'b0, 5'd0,  32'h0);
        step("beq",    32'h10220004, 32'h0000_3050, 32'h0000_0000, 32'h0,         1'b0, 5'd0,  32'h0);
        step("ori0",   32'h34001234, 32'h0000_3054, 32'h0000_1234, 32'h0,         1'b0, 5'd0,  32'h0);
        step("lw0",    32'h8C000000, 32'h0000_3058, 32'h0000_0000, 32'h7777_7777, 1'b0, 5'd0,  32'h0);

        // Reset wins over a live instruction on the same edge.
        reset = 1'b1;
        drive(32'h34021234, 32'h0000_3060, 32'h0000_1234, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst2.IR_W", bus.IR_W, 32'h0);
        check("rst2.WD",   bus.mul_WD, 32'h0);
        check("rst2.cnt",  bus.retire_cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
